// File: rtl/piso.sv
// piso: 4-bit parallel-to-serial transmitter for the scl/sda nibble link.
// Frame: start, four data bits LSB first, stop-phase pulse, stop condition.
module piso #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data,
  input  logic       load,
  output logic       ready,
  output logic       scl,
  output logic       sda,
  output logic       done
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CMAX = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOW,
    HIGH,
    STOP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [3:0]      sh;
  logic [3:0]      sh_n;
  logic [2:0]      idx;
  logic [2:0]      idx_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            last;
  logic            scl_n;
  logic            sda_n;
  logic            ready_n;
  logic            done_n;

  assign last = (cnt == CMAX);

  // FSM, latched word, pulse index and half-period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // next state: each phase lasts HALF cycles, STOP lasts one
  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    cnt_n   = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (load) begin
          sh_n    = data;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (last) begin
          cnt_n   = '0;
          state_n = LOW;
        end
      end
      LOW: begin
        if (last) begin
          cnt_n   = '0;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (last) begin
          cnt_n = '0;
          if (idx == 3'd4) begin
            state_n = STOP;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = LOW;
          end
        end
      end
      STOP: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // output values for the coming cycle, decoded from the next state
  always_comb begin
    scl_n   = 1'b1;
    sda_n   = sda;
    ready_n = 1'b0;
    done_n  = 1'b0;
    unique case (state_n)
      IDLE: begin
        sda_n   = 1'b1;
        ready_n = 1'b1;
      end
      START: begin
        sda_n = 1'b0;
      end
      LOW: begin
        scl_n = 1'b0;
        if (cnt_n != '0) begin
          if (idx_n < 3'd4) begin
            sda_n = sh_n[idx_n[1:0]];
          end else begin
            sda_n = 1'b0;
          end
        end
      end
      HIGH: begin
        sda_n = sda;
      end
      STOP: begin
        sda_n  = 1'b1;
        done_n = 1'b1;
      end
      default: begin
        sda_n   = 1'b1;
        ready_n = 1'b1;
      end
    endcase
  end

  // registered bus outputs; reset parks the bus idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl   <= 1'b1;
      sda   <= 1'b1;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      scl   <= scl_n;
      sda   <= sda_n;
      ready <= ready_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_piso.sv
// tb_piso: scoreboard bench for piso at HALF=4 (ch 0) and HALF=2 (ch 1).
// A bus monitor decodes frames and checks them against pushed words.
module tb_piso;

  logic       clk;
  logic       rst;
  logic [3:0] data_a [2];
  logic       load_a [2];
  logic       ready_a[2];
  logic       scl_a  [2];
  logic       sda_a  [2];
  logic       done_a [2];

  int n_tests;
  int n_fail;

  logic [4:0] sb0[$];
  logic [4:0] sb1[$];

  piso #(.HALF(4)) u4 (
    .clk  (clk),
    .rst  (rst),
    .data (data_a[0]),
    .load (load_a[0]),
    .ready(ready_a[0]),
    .scl  (scl_a[0]),
    .sda  (sda_a[0]),
    .done (done_a[0])
  );

  piso #(.HALF(2)) u2 (
    .clk  (clk),
    .rst  (rst),
    .data (data_a[1]),
    .load (load_a[1]),
    .ready(ready_a[1]),
    .scl  (scl_a[1]),
    .sda  (sda_a[1]),
    .done (done_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bus monitor / receiver model, sampled mid-cycle
  logic       ps  [2];
  logic       pd  [2];
  logic       inf [2];
  int         nb  [2];
  logic [4:0] bits[2];

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      logic s;
      logic d;
      logic [4:0] e;
      s = scl_a[c];
      d = sda_a[c];
      if (rst) begin
        ps[c]   = 1'b1;
        pd[c]   = 1'b1;
        inf[c]  = 1'b0;
        nb[c]   = 0;
        bits[c] = '0;
      end else begin
        if (s && ps[c] && d !== pd[c]) begin
          n_tests++;
          if (!d && !inf[c]) begin
            inf[c]  = 1'b1;
            nb[c]   = 0;
            bits[c] = '0;
          end else if (d && inf[c] && nb[c] == 5) begin
            inf[c] = 1'b0;
            n_tests++;
            if ((c == 0 && sb0.size() == 0) ||
                (c == 1 && sb1.size() == 0)) begin
              n_fail++;
              $display("FAIL rx_unexpected ch%0d got=%b", c, bits[c]);
            end else begin
              e = (c == 0) ? sb0.pop_front() : sb1.pop_front();
              if (bits[c] !== e) begin
                n_fail++;
                $display("FAIL rx_word ch%0d got=%b exp=%b",
                         c, bits[c], e);
              end
            end
          end else begin
            n_fail++;
            $display("FAIL sda_change_scl_high ch%0d sda=%b nb=%0d",
                     c, d, nb[c]);
          end
        end else if (s !== ps[c] && d !== pd[c]) begin
          n_tests++;
          n_fail++;
          $display("FAIL same_edge ch%0d scl=%b sda=%b", c, s, d);
        end
        if (s && !ps[c] && inf[c]) begin
          if (nb[c] < 5) bits[c][nb[c]] = d;
          nb[c]++;
        end
        ps[c] = s;
        pd[c] = d;
      end
    end
  end

  task automatic push(input int ch, input logic [3:0] d);
    if (ch == 0) sb0.push_back({1'b0, d});
    else         sb1.push_back({1'b0, d});
  endtask

  // drive an accept; called at posedge+1, returns in cycle T+1
  task automatic accept(input int ch, input logic [3:0] d);
    n_tests++;
    if (ready_a[ch] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready ch%0d got=%b exp=1", ch, ready_a[ch]);
    end
    push(ch, d);
    data_a[ch] = d;
    load_a[ch] = 1'b1;
    @(posedge clk);
    #1;
    load_a[ch] = 1'b0;
    data_a[ch] = ~d;
    n_tests++;
    if (ready_a[ch] !== 1'b0 || sda_a[ch] !== 1'b0 ||
        scl_a[ch] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_cond ch%0d rdy=%b scl=%b sda=%b exp=0/1/0",
               ch, ready_a[ch], scl_a[ch], sda_a[ch]);
    end
  endtask

  // watch n cycles from T+1; optional load pulse at cycle pk
  task automatic track(
    input  int         ch,
    input  int         n,
    input  int         pk,
    input  logic [3:0] pdat,
    output int         dk,
    output int         nd,
    output int         nr,
    output int         fr,
    output int         lr,
    output int         rk
  );
    logic p;
    dk = 0; nd = 0; nr = 0; fr = 0; lr = 0; rk = 0;
    p = 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (scl_a[ch] && !p) begin
        nr++;
        if (fr == 0) fr = k;
        lr = k;
      end
      p = scl_a[ch];
      if (done_a[ch]) begin
        nd++;
        if (dk == 0) dk = k;
      end
      if (ready_a[ch] && rk == 0) rk = k;
      if (k == pk) begin
        data_a[ch] = pdat;
        load_a[ch] = 1'b1;
      end else begin
        load_a[ch] = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    load_a[ch] = 1'b0;
  endtask

  task automatic chk_frame(
    input string nm, input int h,
    input int dk, input int nd, input int nr,
    input int fr, input int lr, input int rk
  );
    n_tests++;
    if (dk != 11 * h + 1 || nd != 1) begin
      n_fail++;
      $display("FAIL %s_done at=%0d cnt=%0d exp at=%0d cnt=1",
               nm, dk, nd, 11 * h + 1);
    end
    n_tests++;
    if (nr != 5 || fr != 2 * h + 1 || lr != 10 * h + 1) begin
      n_fail++;
      $display("FAIL %s_scl_rises n=%0d first=%0d last=%0d exp 5/%0d/%0d",
               nm, nr, fr, lr, 2 * h + 1, 10 * h + 1);
    end
    n_tests++;
    if (rk != 11 * h + 2) begin
      n_fail++;
      $display("FAIL %s_ready_back at=%0d exp=%0d", nm, rk, 11 * h + 2);
    end
  endtask

  task automatic chk_idle(input string nm, input int ch);
    n_tests++;
    if (scl_a[ch] !== 1'b1 || sda_a[ch] !== 1'b1 ||
        ready_a[ch] !== 1'b1 || done_a[ch] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ch%0d scl/sda/rdy/done=%b%b%b%b exp=1110",
               nm, ch, scl_a[ch], sda_a[ch], ready_a[ch], done_a[ch]);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    chk_idle("reset_async", 0);
    chk_idle("reset_async", 1);
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset_hold", 0);
    chk_idle("reset_hold", 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("reset_release", 0);
  endtask

  task automatic test_single;
    int dk, nd, nr, fr, lr, rk;
    accept(0, 4'b1011);
    track(0, 50, 0, 4'h0, dk, nd, nr, fr, lr, rk);
    chk_frame("single", 4, dk, nd, nr, fr, lr, rk);
  endtask

  task automatic test_busy;
    int dk, nd, nr, fr, lr, rk;
    accept(0, 4'h6);
    track(0, 50, 10, 4'h9, dk, nd, nr, fr, lr, rk);
    chk_frame("busy", 4, dk, nd, nr, fr, lr, rk);
    n_tests++;
    if (sb0.size() != 0 || ready_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_leftover q=%0d rdy=%b exp q=0 rdy=1",
               sb0.size(), ready_a[0]);
    end
  endtask

  task automatic test_back_to_back;
    int d1;
    int d2;
    d1 = 0;
    d2 = 0;
    push(0, 4'h5);
    push(0, 4'hA);
    data_a[0] = 4'h5;
    load_a[0] = 1'b1;
    @(posedge clk);
    #1;
    data_a[0] = 4'hA;
    for (int k = 1; k <= 100; k++) begin
      if (done_a[0]) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
      if (k == 46) begin
        n_tests++;
        if (scl_a[0] !== 1'b1 || sda_a[0] !== 1'b1 ||
            ready_a[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gap scl/sda/rdy=%b%b%b exp=111",
                   scl_a[0], sda_a[0], ready_a[0]);
        end
      end
      if (k == 47) begin
        n_tests++;
        if (sda_a[0] !== 1'b0 || ready_a[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_second_accept sda/rdy=%b%b exp=00",
                   sda_a[0], ready_a[0]);
        end
        load_a[0] = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (d1 != 45 || d2 != 91) begin
      n_fail++;
      $display("FAIL b2b_done at=%0d,%0d exp=45,91", d1, d2);
    end
    n_tests++;
    if (sb0.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_rx_count left=%0d exp=0", sb0.size());
    end
  endtask

  task automatic test_mid_reset;
    int dk, nd, nr, fr, lr, rk;
    accept(0, 4'h9);
    track(0, 25, 0, 4'h0, dk, nd, nr, fr, lr, rk);
    n_tests++;
    if (scl_a[0] !== 1'b1 || nr != 3) begin
      n_fail++;
      $display("FAIL midrst_phase scl=%b rises=%0d exp 1/3",
               scl_a[0], nr);
    end
    #2 rst = 1'b1;
    sb0.delete();
    #1;
    chk_idle("midrst_async", 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_idle("midrst_hold", 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    accept(0, 4'hC);
    track(0, 50, 0, 4'h0, dk, nd, nr, fr, lr, rk);
    chk_frame("midrst_next", 4, dk, nd, nr, fr, lr, rk);
  endtask

  task automatic test_half2;
    int dk, nd, nr, fr, lr, rk;
    accept(1, 4'hF);
    track(1, 30, 0, 4'h0, dk, nd, nr, fr, lr, rk);
    chk_frame("h2_f", 2, dk, nd, nr, fr, lr, rk);
    accept(1, 4'h0);
    track(1, 30, 0, 4'h0, dk, nd, nr, fr, lr, rk);
    chk_frame("h2_0", 2, dk, nd, nr, fr, lr, rk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      data_a[c] = '0;
      load_a[c] = 1'b0;
    end
    test_reset();
    test_single();
    test_busy();
    test_back_to_back();
    test_mid_reset();
    test_half2();
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL rx_missing q0=%0d q1=%0d exp 0/0",
               sb0.size(), sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
